// File: rtl/fp_accum_pkg.sv
// Shared definitions for the floating-point accumulation sequencer.
//   state_t      : sequencer FSM states
//   STAT_*       : bit positions within the 8-bit adder status word
package fp_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int STAT_ZERO    = 0;
  localparam int STAT_INF     = 1;
  localparam int STAT_INVALID = 2;
  localparam int STAT_TINY    = 3;
  localparam int STAT_HUGE    = 4;
  localparam int STAT_INEXACT = 5;

endpackage

// File: rtl/fp_accum_seq.sv
// Streaming FP accumulation sequencer. Drives an external combinational
// adder with the running sum and each incoming operand, registers the adder
// result as the new sum, ORs adder status across the frame and emits one
// (sum, status, count) result per frame.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input element handshake
//   in_data, in_sub, in_last   operand, subtract flag, end-of-frame marker
//   rnd_mode                   rounding mode, captured on first element
//   add_a/add_b/add_op/add_rnd to the adder
//   add_z/add_status           from the adder
//   out_valid/out_ready        result handshake
//   out_sum/out_status/out_count frame result
module fp_accum_seq
  import fp_accum_pkg::*;
#(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int CNT_WIDTH = 8,
  localparam int W = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic                 in_sub,
  input  logic                 in_last,
  input  logic [2:0]           rnd_mode,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_op,
  output logic [2:0]           add_rnd,
  input  logic [W-1:0]         add_z,
  input  logic [7:0]           add_status,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_sum,
  output logic [7:0]           out_status,
  output logic [CNT_WIDTH-1:0] out_count
);

  state_t               state, state_nxt;
  logic [W-1:0]         acc;
  logic [2:0]           rnd_q;
  logic [7:0]           stat_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = in_last ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Register update on each accepted element. The first element of a frame
  // bypasses the adder: the sum is just the operand, sign-flipped if it is
  // to be subtracted, so no rounding or status is introduced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      rnd_q  <= '0;
      stat_q <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        acc    <= {in_data[W-1] ^ in_sub, in_data[W-2:0]};
        rnd_q  <= rnd_mode;
        stat_q <= '0;
        cnt    <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        acc    <= add_z;
        stat_q <= stat_q | add_status;
        if (cnt != {CNT_WIDTH{1'b1}}) cnt <= cnt + 1'b1;
      end
    end
  end

  assign add_a      = acc;
  assign add_b      = in_data;
  assign add_op     = in_sub;
  assign add_rnd    = rnd_q;
  assign out_sum    = acc;
  assign out_status = stat_q;
  assign out_count  = cnt;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Bench for fp_accum_seq. A behavioural single-precision adder stands in for
// the external adder; results are checked against a scoreboard of expected
// frame results pushed when each frame is sent.
module tb_fp_accum_seq;
  import fp_accum_pkg::*;

  typedef struct packed {
    logic [31:0] sum;
    logic [7:0]  status;
    logic [7:0]  count;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [31:0] in_data = '0;
  logic [2:0]  rnd_mode = '0;
  logic        in_ready, add_op, out_valid;
  logic [31:0] add_a, add_b, add_z, out_sum;
  logic [2:0]  add_rnd;
  logic [7:0]  add_status, out_status, out_count;

  // Narrow-counter instance for saturation
  logic        in_valid_s = 1'b0, in_last_s = 1'b0;
  logic        in_ready_s, add_op_s, out_valid_s;
  logic [31:0] add_a_s, add_b_s, add_z_s, out_sum_s;
  logic [2:0]  add_rnd_s;
  logic [7:0]  add_status_s, out_status_s;
  logic [1:0]  out_count_s;

  int   n_err = 0;
  int   n_chk = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  fp_accum_seq #(.SIG_WIDTH(23), .EXP_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sub(in_sub), .in_last(in_last), .rnd_mode(rnd_mode),
    .add_a(add_a), .add_b(add_b), .add_op(add_op), .add_rnd(add_rnd),
    .add_z(add_z), .add_status(add_status), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_status(out_status),
    .out_count(out_count)
  );

  fp_accum_seq #(.SIG_WIDTH(23), .EXP_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .in_data(32'h3F800000), .in_sub(1'b0), .in_last(in_last_s), .rnd_mode(3'd0),
    .add_a(add_a_s), .add_b(add_b_s), .add_op(add_op_s), .add_rnd(add_rnd_s),
    .add_z(add_z_s), .add_status(add_status_s), .out_valid(out_valid_s),
    .out_ready(1'b1), .out_sum(out_sum_s), .out_status(out_status_s),
    .out_count(out_count_s)
  );

  // ---------------- behavioural adder (normal numbers, round-to-nearest-even)
  function automatic real f2r(input logic [31:0] f);
    real p, v;
    int  e;
    e = int'(f[30:23]);
    if (e == 0) return 0.0;
    p = 1.0;
    if (e > 127) repeat (e - 127) p = p * 2.0;
    else         repeat (127 - e) p = p / 2.0;
    v = (1.0 + real'(f[22:0]) / 8388608.0) * p;
    return f[31] ? -v : v;
  endfunction

  function automatic logic [39:0] r2f(input real r);
    logic [63:0] b;
    logic [28:0] rest;
    logic [24:0] mant;
    logic        rup, inexact;
    int          se;
    if (r == 0.0) return {8'h01, 32'h0};
    b       = $realtobits(r);
    se      = int'(b[62:52]) - 896;
    rest    = b[28:0];
    inexact = |rest;
    rup     = rest[28] & ((|rest[27:0]) | b[29]);
    mant    = {2'b01, b[51:29]} + {24'd0, rup};
    if (mant[24]) begin
      se   = se + 1;
      mant = 25'd0;
    end
    if (se >= 255) return {8'h32, b[63], 8'hFF, 23'd0};
    if (se <= 0)   return {8'h29, b[63], 31'd0};
    return {2'b00, inexact, 5'd0, b[63], se[7:0], mant[22:0]};
  endfunction

  function automatic logic [39:0] fp_add(input logic [31:0] a, input logic [31:0] bb,
                                         input logic sub);
    return r2f(sub ? f2r(a) - f2r(bb) : f2r(a) + f2r(bb));
  endfunction

  always_comb {add_status, add_z}     = fp_add(add_a, add_b, add_op);
  always_comb {add_status_s, add_z_s} = fp_add(add_a_s, add_b_s, add_op_s);

  // ---------------- checking
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Scoreboard monitor: compare each delivered frame result
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(out_sum), 64'hDEAD);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("out_sum",    64'(out_sum),    64'(e.sum));
        chk("out_status", 64'(out_status), 64'(e.status));
        chk("out_count",  64'(out_count),  64'(e.count));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   64'(in_ready),   64'd1);
    chk({tag, "_out_valid"},  64'(out_valid),  64'd0);
    chk({tag, "_out_sum"},    64'(out_sum),    64'd0);
    chk({tag, "_out_status"}, 64'(out_status), 64'd0);
    chk({tag, "_out_count"},  64'(out_count),  64'd0);
    chk({tag, "_add_rnd"},    64'(add_rnd),    64'd0);
    chk({tag, "_add_a"},      64'(add_a),      64'd0);
  endtask

  // Drive one element; inputs change #1 after a rising edge.
  task automatic send(input logic [31:0] d, input logic sub, input logic last,
                      input int max_gap);
    int t;
    if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 50) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_sub = 1'b0;
    if (last) chk("latency_out_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic expect_res(input logic [31:0] s, input logic [7:0] st, input logic [7:0] c);
    res_t e;
    e.sum = s; e.status = st; e.count = c;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 100) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #13;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three-element add
    expect_res(32'h40C00000, 8'h00, 8'd3);
    send(32'h3F800000, 1'b0, 1'b0, 0);
    send(32'h40000000, 1'b0, 1'b0, 0);
    send(32'h40400000, 1'b0, 1'b1, 0);
    drain();

    // Subtraction with first-element negation: -3 - 1
    expect_res(32'hC0800000, 8'h00, 8'd2);
    send(32'h40400000, 1'b1, 1'b0, 0);
    send(32'h3F800000, 1'b1, 1'b1, 0);
    drain();

    // Overflow, then status clear on the next frame
    expect_res(32'h7F800000, 8'h32, 8'd2);
    send(32'h7F7FFFFF, 1'b0, 1'b0, 0);
    send(32'h7F7FFFFF, 1'b0, 1'b1, 0);
    drain();
    expect_res(32'h3F800000, 8'h00, 8'd1);
    send(32'h3F800000, 1'b0, 1'b1, 0);
    drain();

    // Output backpressure: result must stay put, input blocked
    out_ready = 1'b0;
    expect_res(32'h40C00000, 8'h00, 8'd3);
    send(32'h3F800000, 1'b0, 1'b0, 0);
    send(32'h40000000, 1'b0, 1'b0, 0);
    send(32'h40400000, 1'b0, 1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_out_sum",   64'(out_sum),   64'h40C00000);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    drain();

    // Input gaps and a mid-frame rounding-mode change
    expect_res(32'h40C00000, 8'h00, 8'd3);
    rnd_mode = 3'd2;
    send(32'h3F800000, 1'b0, 1'b0, 3);
    rnd_mode = 3'd0;
    chk("rnd_captured", 64'(add_rnd), 64'd2);
    send(32'h40000000, 1'b0, 1'b0, 3);
    chk("rnd_held", 64'(add_rnd), 64'd2);
    send(32'h40400000, 1'b0, 1'b1, 3);
    drain();

    // Reset mid-frame: aborted frame produces nothing
    send(32'h40000000, 1'b0, 1'b0, 0);
    send(32'h40000000, 1'b0, 1'b0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_res(32'h40000000, 8'h00, 8'd2);
    send(32'h3F800000, 1'b0, 1'b0, 0);
    send(32'h3F800000, 1'b0, 1'b1, 0);
    drain();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    // Counter saturation on the 2-bit instance
    in_valid_s = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_last_s = (i == 4);
      @(posedge clk); #1;
    end
    in_valid_s = 1'b0; in_last_s = 1'b0;
    chk("sat_out_valid", 64'(out_valid_s), 64'd1);
    chk("sat_out_count", 64'(out_count_s), 64'd3);
    chk("sat_out_sum",   64'(out_sum_s),   64'h40A00000);
    chk("sat_out_status", 64'(out_status_s), 64'd0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
